// File: rtl/mem_responder.sv
// Shared-RAM responder for the data and instruction caches: one access at a time,
// data port has priority, each access waits LAT cycles before completing.
module mem_responder #(
    parameter int          LAT     = 2,
    parameter int          DEPTH   = 256,
    parameter int          AW      = $clog2(DEPTH),
    parameter logic [31:0] BADDATA = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    output logic [0:0]  o_dbg_state
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;
    localparam logic [3:0] LAT_C    = LAT[3:0];

    logic [0:0]  r_state;
    logic        r_grant_d;
    logic        r_op_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem [DEPTH];

    logic          w_d_req;
    logic          w_abort;
    logic          w_done;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rdata;

    assign w_d_req    = dREN | dWEN;
    assign w_abort    = (r_state == S_ACCESS) && (r_grant_d ? !w_d_req : !iREN);
    assign w_done     = (r_state == S_ACCESS) && !w_abort && (r_cnt == LAT_C);
    assign w_in_range = (r_addr[31:AW+2] == '0);
    assign w_idx      = r_addr[AW+1:2];
    assign w_rdata    = w_in_range ? r_mem[w_idx] : BADDATA;

    // Wait is released only in the completion cycle, and only on the granted port.
    assign dwait       = !(w_done && r_grant_d);
    assign iwait       = !(w_done && !r_grant_d);
    assign dload       = (w_done && r_grant_d && !r_op_wr) ? w_rdata : 32'h0;
    assign iload       = (w_done && !r_grant_d) ? w_rdata : 32'h0;
    assign o_dbg_state = r_state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_grant_d <= 1'b0;
            r_op_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_d_req) begin
                        r_state   <= S_ACCESS;
                        r_grant_d <= 1'b1;
                        r_op_wr   <= dWEN;
                        r_addr    <= daddr;
                        r_wdata   <= dstore;
                        r_cnt     <= '0;
                    end else if (iREN) begin
                        r_state   <= S_ACCESS;
                        r_grant_d <= 1'b0;
                        r_op_wr   <= 1'b0;
                        r_addr    <= iaddr;
                        r_cnt     <= '0;
                    end
                end
                S_ACCESS: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_done) begin
                        r_state <= S_IDLE;
                        // Out-of-range writes complete but are silently dropped.
                        if (r_op_wr && w_in_range) begin
                            r_mem[w_idx] <= r_wdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, data, priority, abort, range and reset cases.
module tb_mem_responder;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dREN, dWEN, iREN;
    logic [31:0] daddr, dstore, iaddr;
    logic        dwait, iwait;
    logic [31:0] dload, iload;
    logic [0:0]  o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    mem_responder #(.LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .o_dbg_state(o_dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One isolated access; starts and ends just after a rising edge with the FSM idle.
    task automatic access(input bit is_d, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_load, input string tag);
        int n;
        int other_low;
        n = 0;
        other_low = 0;
        if (is_d) begin
            dREN = !wr; dWEN = wr; daddr = a; dstore = d;
        end else begin
            iREN = 1'b1; iaddr = a;
        end
        @(negedge CLK);
        while ((is_d ? dwait : iwait) && n < 20) begin
            if (!(is_d ? iwait : dwait)) other_low++;
            n++;
            @(negedge CLK);
        end
        check_eq({tag, "_lat"}, n, LAT + 1);
        check_eq({tag, "_load"}, is_d ? dload : iload, (is_d && wr) ? 32'h0 : exp_load);
        check_eq({tag, "_other_wait"}, other_low, 0);
        step();
        dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
        @(negedge CLK);
        check_eq({tag, "_wait_one_cycle"}, is_d ? dwait : iwait, 1);
        step();
    endtask

    initial begin
        int n, dk, ik, iwait_early, low_cnt;
        logic [31:0] dv, iv;

        RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
        daddr = '0; dstore = '0; iaddr = '0;
        step();
        step();
        RST = 1'b0;
        @(negedge CLK);
        check_eq("rst_dwait", dwait, 1);
        check_eq("rst_iwait", iwait, 1);
        check_eq("rst_dload", dload, 0);
        check_eq("rst_iload", iload, 0);
        step();

        // Write then read back the same word.
        access(1, 1, 32'h10, 32'hDEADBEEF, 0, "wr10");
        access(1, 0, 32'h10, 0, 32'hDEADBEEF, "rd10");

        // Two-word line fill with the read request held across both words.
        access(1, 1, 32'h20, 32'h11, 0, "pre20");
        access(1, 1, 32'h24, 32'h22, 0, "pre24");
        dREN = 1'b1; daddr = 32'h20;
        n = 0;
        @(negedge CLK);
        while (dwait && n < 20) begin n++; @(negedge CLK); end
        check_eq("fill0_lat", n, LAT + 1);
        check_eq("fill0_data", dload, 32'h11);
        n = 0;
        do begin
            step();
            daddr = 32'h24;
            @(negedge CLK);
            n++;
        end while (dwait && n < 20);
        check_eq("fill1_gap", n, LAT + 2);
        check_eq("fill1_data", dload, 32'h22);
        step();
        dREN = 1'b0;
        step();

        // Simultaneous D and I requests; D is dropped once it completes.
        dREN = 1'b1; daddr = 32'h20; iREN = 1'b1; iaddr = 32'h10;
        dk = -1; ik = -1; iwait_early = 0; dv = '0; iv = '0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) begin
                step();
                if (dk >= 0) dREN = 1'b0;
            end
            @(negedge CLK);
            if (!dwait && dk < 0) begin dk = k; dv = dload; end
            if (!iwait && ik < 0) begin ik = k; iv = iload; end
            if (!iwait && dk < 0) iwait_early++;
        end
        check_eq("prio_d_cycle", dk, LAT + 1);
        check_eq("prio_i_gap", ik - dk, LAT + 2);
        check_eq("prio_d_data", dv, 32'h11);
        check_eq("prio_i_data", iv, 32'hDEADBEEF);
        check_eq("prio_iwait_during_d", iwait_early, 0);
        step();
        iREN = 1'b0;
        step();

        // Write aborted after one ACCESS cycle must never complete.
        dWEN = 1'b1; daddr = 32'h30; dstore = 32'h55;
        low_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                step();
                if (k == 2) dWEN = 1'b0;
            end
            @(negedge CLK);
            if (!dwait) low_cnt++;
        end
        check_eq("abort_no_complete", low_cnt, 0);
        step();
        access(1, 0, 32'h30, 0, 32'h0, "abort_rd30");

        // Out-of-range read and write; word 0 must survive the write.
        access(1, 1, 32'h0, 32'hA5A5A5A5, 0, "wr0");
        access(1, 0, 32'h400, 0, 32'hBAD1BAD1, "oor_rd");
        access(1, 1, 32'h400, 32'h12345678, 0, "oor_wr");
        access(1, 0, 32'h0, 0, 32'hA5A5A5A5, "rd0_kept");

        // Instruction fetch alone.
        access(0, 0, 32'h24, 0, 32'h22, "ifetch24");

        // Reset in the cnt=1 cycle of a write.
        dWEN = 1'b1; daddr = 32'h40; dstore = 32'h77;
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0; dWEN = 1'b0;
        @(negedge CLK);
        check_eq("mid_rst_dwait", dwait, 1);
        check_eq("mid_rst_iwait", iwait, 1);
        check_eq("mid_rst_dload", dload, 0);
        check_eq("mid_rst_iload", iload, 0);
        step();
        access(1, 0, 32'h40, 0, 32'h0, "rst_rd40");
        access(1, 0, 32'h10, 0, 32'h0, "rst_cleared10");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
